pwr_rst_seq: RTL and testbench
==============================

PWR_RST_SEQ -- requirements
Module: pwr_rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of sequenced reset channels (1..8).
REQ-002 SHALL have parameter DCOK_DLY, default 65536, cycles to wait after reset release before sequencing starts.
REQ-003 SHALL have parameter STEP_DLY, default 256, cycles between a channel's power-good qualification and its reset release, and between successive reset assertions on power-down.
REQ-004 SHALL have parameter PG_FILT, default 8, cycles a synchronised power-good level must hold before it is accepted.
REQ-005 SHALL have parameter PG_TMO, default 1048576, maximum cycles spent waiting for one channel's power-good.
REQ-006 SHALL have port i_InitialSoc, input, 1, the only clock.
REQ-007 SHALL have port i_DCOKSby, input, 1, reset, asynchronous assert, active-low.
REQ-008 SHALL have port i_PwrGood, input, N_CH, per-channel power-good, asynchronous to i_InitialSoc.
REQ-009 SHALL have port i_SoftRst_n, input, 1, synchronous active-low request to re-sequence all channels.
REQ-010 SHALL have port i_Retry, input, 1, synchronous pulse that leaves HALT.
REQ-011 SHALL have port o_Reset_n, output, N_CH, per-channel active-low reset.
REQ-012 SHALL have port o_Fault, output, N_CH, sticky per-channel fault flags.
REQ-013 SHALL have port o_AllReady, output, 1, high only in RUN.
REQ-014 SHALL have port o_State, output, 3, current FSM state encoding.

Function
REQ-015 SHALL drive i_DCOKSby deassertion through a 2-flop synchroniser; internal logic leaves reset on the 2nd rising clock edge after deassertion.
REQ-016 SHALL pass each i_PwrGood bit through a 2-flop synchroniser and then a PG_FILT-cycle filter; the filtered level changes only after PG_FILT consecutive equal samples.
REQ-017 SHALL implement the states WAIT_DCOK=0, SEQ_UP=1, RUN=2, SEQ_DN=3 and HALT=4.
REQ-018 SHALL stay in WAIT_DCOK for exactly DCOK_DLY cycles, then enter SEQ_UP with the channel index at 0.
REQ-019 SHALL, in SEQ_UP, wait for filtered PG[idx] high, count STEP_DLY cycles, then drive o_Reset_n[idx] high; if idx=N_CH-1 it SHALL enter RUN, otherwise increment idx.
REQ-020 SHALL, in SEQ_UP, set o_Fault[idx] and enter SEQ_DN when PG_TMO cycles elapse without filtered PG[idx] high.
REQ-021 SHALL, in SEQ_UP or RUN, set o_Fault[k] and enter SEQ_DN when the filtered PG of any already-released channel k falls.
REQ-022 SHALL, in RUN, enter SEQ_DN without setting any fault when i_SoftRst_n is sampled low.
REQ-023 SHALL, in SEQ_DN, drive o_Reset_n low immediately for every channel whose PG has failed, then drive the remaining released channels low one per STEP_DLY cycles in descending index order.
REQ-024 SHALL, after SEQ_DN, go to HALT if any o_Fault bit is set, otherwise to WAIT_DCOK.
REQ-025 SHALL, in HALT, clear o_Fault and enter WAIT_DCOK when i_Retry is sampled high.
REQ-026 SHALL, when a fault and a soft reset occur in the same cycle, record the fault and end in HALT.
REQ-027 SHALL, when faults occur on several channels in the same cycle, set every affected o_Fault bit.
REQ-028 SHALL size every counter with $clog2 of its parameter, and SHALL saturate counters rather than wrap.
REQ-029 SHALL change o_Reset_n only on i_InitialSoc edges or on i_DCOKSby assertion (glitch-free, registered).

Reset
REQ-030 SHALL, while i_DCOKSby is low, hold o_Reset_n=0, o_Fault=0, o_AllReady=0, o_State=WAIT_DCOK, all counters and filters at 0 and idx at 0.
REQ-031 SHALL, on assertion of i_DCOKSby at any point mid-sequence, drive all o_Reset_n low asynchronously in the same instant.

Structure
REQ-032 SHALL place the state encoding and the default parameter constants in the shared package pwr_rst_pkg.
REQ-033 SHALL implement the per-channel synchroniser and filter as sub-module pg_filt, instantiated N_CH times.

Verification (N_CH=3, DCOK_DLY=16, STEP_DLY=4, PG_FILT=3, PG_TMO=32)
REQ-034 SHALL verify power-up: with all PG high, release i_DCOKSby -> o_Reset_n[0] rises at edge 22, [1] at 26, [2] at 30, o_AllReady=1 at edge 30.
REQ-035 SHALL verify timeout: with PG[1] held low -> o_Fault=3'b010 and o_Reset_n[0] falling STEP_DLY cycles after the timeout, then HALT.
REQ-036 SHALL verify brown-out: drop PG[2] in RUN -> o_Reset_n[2] falls PG_FILT+2 cycles later, then [1] and [0] fall 4 cycles apart, ending in HALT.
REQ-037 SHALL verify glitch rejection: a 2-cycle low pulse on PG[0] in RUN -> no fault and o_AllReady stays 1.
REQ-038 SHALL verify soft reset: a 1-cycle low pulse on i_SoftRst_n in RUN -> descending power-down, o_Fault=0, full re-sequence from WAIT_DCOK.
REQ-039 SHALL verify async reset: assert i_DCOKSby mid-SEQ_DN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pwr_rst_pkg.sv
// pwr_rst_pkg: shared definitions for the power/reset sequencer.
//   - pwr_state_e : FSM state encoding (also driven out on o_State)
//   - DEF_*       : default parameter values
//   - cnt_w()     : counter width for a given count limit (min 1 bit)
package pwr_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_DCOK = 3'd0,
        ST_SEQ_UP    = 3'd1,
        ST_RUN       = 3'd2,
        ST_SEQ_DN    = 3'd3,
        ST_HALT      = 3'd4
    } pwr_state_e;

    localparam int unsigned DEF_N_CH     = 4;
    localparam int unsigned DEF_DCOK_DLY = 65536;
    localparam int unsigned DEF_STEP_DLY = 256;
    localparam int unsigned DEF_PG_FILT  = 8;
    localparam int unsigned DEF_PG_TMO   = 1048576;

    function automatic int unsigned cnt_w(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/pwr_rst_seq_if.sv
// pwr_rst_seq_if: bundle of the sequencer's per-channel and control signals.
//   master : the board/controller side (drives power-good, soft reset, retry)
//   slave  : the sequencer side (drives resets, faults, ready, state)
interface pwr_rst_seq_if
    import pwr_rst_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
);
    logic [N_CH-1:0] pwr_good;
    logic            soft_rst_n;
    logic            retry;
    logic [N_CH-1:0] reset_n;
    logic [N_CH-1:0] fault;
    logic            all_ready;
    logic [2:0]      state;

    modport master (
        output pwr_good, soft_rst_n, retry,
        input  reset_n, fault, all_ready, state
    );

    modport slave (
        input  pwr_good, soft_rst_n, retry,
        output reset_n, fault, all_ready, state
    );
endinterface

// File: rtl/pg_filt.sv
// pg_filt: 2-flop synchroniser plus level filter for one power-good input.
//   clk      : sequencer clock
//   rst_n    : internal reset (async assert, active-low)
//   pg_async : raw power-good, asynchronous to clk
//   pg_o     : filtered level; it takes a new value on the cycle the
//              PG_FILT-th consecutive differing synchronised sample is seen
module pg_filt
    import pwr_rst_pkg::*;
#(
    parameter int unsigned PG_FILT = DEF_PG_FILT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pg_async,
    output logic pg_o
);
    localparam int unsigned FW = cnt_w(PG_FILT);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [FW-1:0] cnt_q, cnt_d;

    // cnt_q holds how many earlier consecutive samples disagreed with the
    // accepted level, so the current sample completes the run; the count
    // never exceeds PG_FILT-1.
    always_comb begin
        sync_d  = {sync_q[0], pg_async};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == FW'(PG_FILT - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pg_o = level_d;
endmodule

// File: rtl/pwr_rst_seq.sv
// pwr_rst_seq: power-good qualified reset sequencer for N_CH channels.
//   i_InitialSoc : clock
//   i_DCOKSby    : async-assert active-low reset (release synchronised)
//   i_PwrGood    : per-channel power-good (asynchronous)
//   i_SoftRst_n  : sync active-low request to power down and re-sequence
//   i_Retry      : sync pulse leaving HALT
//   o_Reset_n    : per-channel active-low resets (registered)
//   o_Fault      : sticky per-channel fault flags
//   o_AllReady   : high in RUN
//   o_State      : FSM state
module pwr_rst_seq
    import pwr_rst_pkg::*;
#(
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned DCOK_DLY = DEF_DCOK_DLY,
    parameter int unsigned STEP_DLY = DEF_STEP_DLY,
    parameter int unsigned PG_FILT  = DEF_PG_FILT,
    parameter int unsigned PG_TMO   = DEF_PG_TMO
) (
    input  logic            i_InitialSoc,
    input  logic            i_DCOKSby,
    input  logic [N_CH-1:0] i_PwrGood,
    input  logic            i_SoftRst_n,
    input  logic            i_Retry,
    output logic [N_CH-1:0] o_Reset_n,
    output logic [N_CH-1:0] o_Fault,
    output logic            o_AllReady,
    output logic [2:0]      o_State
);
    localparam int unsigned DW = cnt_w(DCOK_DLY);
    localparam int unsigned SW = cnt_w(STEP_DLY);
    localparam int unsigned TW = cnt_w(PG_TMO);
    localparam int unsigned IW = cnt_w(N_CH);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge i_InitialSoc or negedge i_DCOKSby) begin
        if (!i_DCOKSby) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    // Every other flop resets from this, so assertion still propagates
    // combinationally from i_DCOKSby with no clock.
    assign rst_int_n = rst_sync_q[1];

    logic [N_CH-1:0] pg_f;

    for (genvar g = 0; g < N_CH; g++) begin : g_pg
        pg_filt #(.PG_FILT(PG_FILT)) u_pg_filt (
            .clk      (i_InitialSoc),
            .rst_n    (rst_int_n),
            .pg_async (i_PwrGood[g]),
            .pg_o     (pg_f[g])
        );
    end

    pwr_state_e      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   dly_cnt_q, dly_cnt_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [N_CH-1:0] reset_n_q, reset_n_d;
    logic [N_CH-1:0] fault_q, fault_d;

    logic [N_CH-1:0] fail_vec;
    logic [N_CH-1:0] keep;
    logic [IW-1:0]   hi;
    logic            tmo_hit;

    // A released channel whose filtered power-good is low has failed.
    assign fail_vec = reset_n_q & ~pg_f;
    assign keep     = reset_n_q & pg_f;
    assign tmo_hit  = !pg_f[idx_q] && (tmo_cnt_q == TW'(PG_TMO - 1));

    // Highest channel still released after dropping failed ones.
    always_comb begin
        hi = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (keep[k]) hi = IW'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dly_cnt_d  = dly_cnt_q;
        step_cnt_d = step_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        reset_n_d  = reset_n_q;
        fault_d    = fault_q;

        case (state_q)
            ST_WAIT_DCOK: begin
                if (dly_cnt_q == DW'(DCOK_DLY - 1)) begin
                    state_d    = ST_SEQ_UP;
                    idx_d      = '0;
                    dly_cnt_d  = '0;
                    step_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end

            ST_SEQ_UP: begin
                if ((|fail_vec) || tmo_hit) begin
                    fault_d    = fault_q | fail_vec |
                                 (tmo_hit ? (N_CH'(1) << idx_q) : '0);
                    reset_n_d  = reset_n_q & ~fail_vec;
                    step_cnt_d = '0;
                    state_d    = ST_SEQ_DN;
                end else if (pg_f[idx_q]) begin
                    if (step_cnt_q == SW'(STEP_DLY - 1)) begin
                        reset_n_d[idx_q] = 1'b1;
                        step_cnt_d       = '0;
                        tmo_cnt_d        = '0;
                        if (idx_q == IW'(N_CH - 1)) state_d = ST_RUN;
                        else                        idx_d   = idx_q + 1'b1;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end else begin
                    step_cnt_d = '0;
                    tmo_cnt_d  = tmo_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                step_cnt_d = '0;
                if (|fail_vec) begin
                    fault_d   = fault_q | fail_vec;
                    reset_n_d = reset_n_q & ~fail_vec;
                    state_d   = ST_SEQ_DN;
                end else if (!i_SoftRst_n) begin
                    state_d = ST_SEQ_DN;
                end
            end

            ST_SEQ_DN: begin
                reset_n_d = keep;
                if (reset_n_q == '0) begin
                    dly_cnt_d = '0;
                    state_d   = (|fault_q) ? ST_HALT : ST_WAIT_DCOK;
                end else if (step_cnt_q == SW'(STEP_DLY - 1)) begin
                    if (|keep) reset_n_d[hi] = 1'b0;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end

            ST_HALT: begin
                if (i_Retry) begin
                    fault_d   = '0;
                    dly_cnt_d = '0;
                    state_d   = ST_WAIT_DCOK;
                end
            end

            default: state_d = ST_WAIT_DCOK;
        endcase
    end

    always_ff @(posedge i_InitialSoc or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_WAIT_DCOK;
            idx_q      <= '0;
            dly_cnt_q  <= '0;
            step_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            reset_n_q  <= '0;
            fault_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dly_cnt_q  <= dly_cnt_d;
            step_cnt_q <= step_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            reset_n_q  <= reset_n_d;
            fault_q    <= fault_d;
        end
    end

    assign o_Reset_n  = reset_n_q;
    assign o_Fault    = fault_q;
    assign o_AllReady = (state_q == ST_RUN);
    assign o_State    = state_q;
endmodule

// File: tb/tb_pwr_rst_seq.sv
// tb_pwr_rst_seq: directed bench for pwr_rst_seq with N_CH=3, DCOK_DLY=16,
// STEP_DLY=4, PG_FILT=3, PG_TMO=32. Every expected reset edge is queued with
// its clock-edge number; a monitor pops and compares on each o_Reset_n change.
module tb_pwr_rst_seq;
    import pwr_rst_pkg::*;

    logic clk;
    logic dcok;
    int unsigned edge_cnt = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [2:0] prev = '0;

    typedef struct {
        int unsigned edge_no;
        logic [2:0]  val;
    } ev_t;
    ev_t exp_q[$];

    pwr_rst_seq_if #(.N_CH(3)) bus ();

    pwr_rst_seq #(
        .N_CH     (3),
        .DCOK_DLY (16),
        .STEP_DLY (4),
        .PG_FILT  (3),
        .PG_TMO   (32)
    ) dut (
        .i_InitialSoc (clk),
        .i_DCOKSby    (dcok),
        .i_PwrGood    (bus.pwr_good),
        .i_SoftRst_n  (bus.soft_rst_n),
        .i_Retry      (bus.retry),
        .o_Reset_n    (bus.reset_n),
        .o_Fault      (bus.fault),
        .o_AllReady   (bus.all_ready),
        .o_State      (bus.state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int unsigned e, input logic [2:0] v);
        ev_t ev;
        ev.edge_no = e;
        ev.val     = v;
        exp_q.push_back(ev);
    endtask

    // Returns 1 ns after posedge number n.
    task automatic goto_edge(input int unsigned n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus.reset_n != prev)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_reset_change", 32'(exp_q.size()), 32'd1);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                chk("reset_edge_no", 32'(edge_cnt), 32'(ev.edge_no));
                chk("reset_value", 32'(bus.reset_n), 32'(ev.val));
            end
        end
        prev <= bus.reset_n;
    end

    initial begin
        int unsigned base;
        bus.pwr_good   = 3'b111;
        bus.soft_rst_n = 1'b1;
        bus.retry      = 1'b0;
        dcok           = 1'b0;

        goto_edge(3);
        chk("rst_reset_n", 32'(bus.reset_n), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_all_ready", 32'(bus.all_ready), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(ST_WAIT_DCOK));
        mon_en = 1'b1;

        // Power-up
        base = edge_cnt;
        dcok = 1'b1;
        push_ev(base + 22, 3'b001);
        push_ev(base + 26, 3'b011);
        push_ev(base + 30, 3'b111);
        goto_edge(base + 17);
        chk("up_still_wait", 32'(bus.state), 32'(ST_WAIT_DCOK));
        goto_edge(base + 18);
        chk("up_enter_seq_up", 32'(bus.state), 32'(ST_SEQ_UP));
        goto_edge(base + 29);
        chk("up_not_ready_29", 32'(bus.all_ready), 32'd0);
        goto_edge(base + 30);
        chk("up_ready_30", 32'(bus.all_ready), 32'd1);
        chk("up_state_run", 32'(bus.state), 32'(ST_RUN));

        // Glitch rejection: 2-cycle low on PG[0]
        base = edge_cnt;
        bus.pwr_good[0] = 1'b0;
        goto_edge(base + 2);
        bus.pwr_good[0] = 1'b1;
        goto_edge(base + 12);
        chk("glitch_fault", 32'(bus.fault), 32'd0);
        chk("glitch_ready", 32'(bus.all_ready), 32'd1);

        // Soft reset: descending power-down then full re-sequence
        base = edge_cnt;
        bus.soft_rst_n = 1'b0;
        goto_edge(base + 1);
        bus.soft_rst_n = 1'b1;
        push_ev(base + 5, 3'b011);
        push_ev(base + 9, 3'b001);
        push_ev(base + 13, 3'b000);
        push_ev(base + 34, 3'b001);
        push_ev(base + 38, 3'b011);
        push_ev(base + 42, 3'b111);
        goto_edge(base + 2);
        chk("soft_seq_dn", 32'(bus.state), 32'(ST_SEQ_DN));
        goto_edge(base + 14);
        chk("soft_wait", 32'(bus.state), 32'(ST_WAIT_DCOK));
        chk("soft_no_fault", 32'(bus.fault), 32'd0);
        goto_edge(base + 30);
        chk("soft_seq_up", 32'(bus.state), 32'(ST_SEQ_UP));
        goto_edge(base + 42);
        chk("soft_run", 32'(bus.state), 32'(ST_RUN));

        // Brown-out on PG[2]
        base = edge_cnt;
        bus.pwr_good[2] = 1'b0;
        push_ev(base + 5, 3'b011);
        push_ev(base + 9, 3'b001);
        push_ev(base + 13, 3'b000);
        goto_edge(base + 4);
        chk("bo_still_run", 32'(bus.state), 32'(ST_RUN));
        goto_edge(base + 5);
        chk("bo_fault", 32'(bus.fault), 32'b100);
        chk("bo_seq_dn", 32'(bus.state), 32'(ST_SEQ_DN));
        goto_edge(base + 14);
        chk("bo_halt", 32'(bus.state), 32'(ST_HALT));
        bus.pwr_good[2] = 1'b1;
        goto_edge(base + 20);
        chk("bo_halt_hold", 32'(bus.state), 32'(ST_HALT));
        chk("bo_fault_sticky", 32'(bus.fault), 32'b100);

        // Retry back to RUN
        base = edge_cnt;
        bus.retry = 1'b1;
        goto_edge(base + 1);
        bus.retry = 1'b0;
        chk("retry_fault_clr", 32'(bus.fault), 32'd0);
        chk("retry_wait", 32'(bus.state), 32'(ST_WAIT_DCOK));
        push_ev(base + 21, 3'b001);
        push_ev(base + 25, 3'b011);
        push_ev(base + 29, 3'b111);
        goto_edge(base + 29);
        chk("retry_ready", 32'(bus.all_ready), 32'd1);

        // PG[0] and PG[1] fail while a soft reset lands on the same edge
        base = edge_cnt;
        bus.pwr_good[1:0] = 2'b00;
        goto_edge(base + 4);
        bus.soft_rst_n = 1'b0;
        push_ev(base + 5, 3'b100);
        push_ev(base + 9, 3'b000);
        goto_edge(base + 5);
        bus.soft_rst_n = 1'b1;
        chk("multi_fault", 32'(bus.fault), 32'b011);
        goto_edge(base + 10);
        chk("multi_halt", 32'(bus.state), 32'(ST_HALT));

        // Timeout on PG[1]
        bus.pwr_good = 3'b101;
        goto_edge(edge_cnt + 8);
        base = edge_cnt;
        bus.retry = 1'b1;
        goto_edge(base + 1);
        bus.retry = 1'b0;
        base = base + 1;
        push_ev(base + 20, 3'b001);
        push_ev(base + 56, 3'b000);
        goto_edge(base + 51);
        chk("tmo_pending_fault", 32'(bus.fault), 32'd0);
        chk("tmo_pending_state", 32'(bus.state), 32'(ST_SEQ_UP));
        goto_edge(base + 52);
        chk("tmo_fault", 32'(bus.fault), 32'b010);
        chk("tmo_seq_dn", 32'(bus.state), 32'(ST_SEQ_DN));
        goto_edge(base + 57);
        chk("tmo_halt", 32'(bus.state), 32'(ST_HALT));

        // Recover, then assert i_DCOKSby in the middle of a power-down
        bus.pwr_good = 3'b111;
        goto_edge(edge_cnt + 8);
        base = edge_cnt;
        bus.retry = 1'b1;
        goto_edge(base + 1);
        bus.retry = 1'b0;
        push_ev(base + 21, 3'b001);
        push_ev(base + 25, 3'b011);
        push_ev(base + 29, 3'b111);
        goto_edge(base + 29);
        base = edge_cnt;
        bus.soft_rst_n = 1'b0;
        goto_edge(base + 1);
        bus.soft_rst_n = 1'b1;
        push_ev(base + 5, 3'b011);
        goto_edge(base + 7);
        chk("async_pre_state", 32'(bus.state), 32'(ST_SEQ_DN));
        mon_en = 1'b0;
        #2;
        dcok = 1'b0;
        #1;
        chk("async_reset_n", 32'(bus.reset_n), 32'd0);
        chk("async_fault", 32'(bus.fault), 32'd0);
        chk("async_ready", 32'(bus.all_ready), 32'd0);
        chk("async_state", 32'(bus.state), 32'(ST_WAIT_DCOK));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
